// File: rtl/rf_pkt_ctrl.sv
// rf_pkt_ctrl: sync-word packet receiver with host byte drain, plus a bit-strobed byte serialiser
module rf_pkt_ctrl #(
    parameter int                DW        = 8,
    parameter int                PKT_BYTES = 8,
    parameter int                SYNC_W    = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hA5C3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          rfin,
    input  logic          bit_en,
    output logic [DW-1:0] rx_byte,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          pkt_rec,
    output logic          pkt_drop,
    input  logic [DW-1:0] tx_byte,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_out,
    output logic          tx_busy
);
    localparam int PW  = PKT_BYTES * DW;
    localparam int BCW = $clog2(PW) + 1;
    localparam int IW  = $clog2(PKT_BYTES) + 1;
    localparam int TCW = $clog2(DW) + 1;

    typedef enum logic [1:0] {R_HUNT, R_PAYLOAD, R_DRAIN} rx_state_t;
    typedef enum logic {T_IDLE, T_SHIFT} tx_state_t;

    rx_state_t         rx_state;
    tx_state_t         tx_state;
    logic [1:0]        rfin_s;
    logic [1:0]        ben_s;
    logic              ben_d;
    logic [SYNC_W-1:0] sync_sr;
    logic [PW-1:0]     pay;
    logic [BCW-1:0]    bit_cnt;
    logic [IW-1:0]     idx;
    logic [DW-1:0]     tx_sr;
    logic [TCW-1:0]    tx_cnt;
    logic              bit_ev;
    logic              rx_bit;
    logic [SYNC_W-1:0] sync_nx;
    logic              sync_hit;
    logic [PW-1:0]     pay_nx;
    logic              rx_hs;
    logic              rx_last;
    logic              tx_hs;

    assign bit_ev   = ben_s[1] & ~ben_d;
    assign rx_bit   = rfin_s[1];
    assign sync_nx  = {sync_sr[SYNC_W-2:0], rx_bit};
    assign sync_hit = bit_ev && (sync_nx == SYNC_WORD);
    assign pay_nx   = {pay[PW-2:0], rx_bit};
    assign rx_hs    = rx_valid && rx_ready;
    assign rx_last  = idx == IW'(PKT_BYTES - 1);
    assign tx_hs    = tx_valid && tx_ready;

    // byte 0 is the first received, sitting in the top DW bits of the buffer
    function automatic logic [DW-1:0] byte_at(input logic [PW-1:0] b, input logic [IW-1:0] i);
        logic [PW-1:0] sh;
        sh = b << (int'(i) * DW);
        return sh[PW-1 -: DW];
    endfunction

    // two-flop synchronisers for the RF inputs plus strobe history for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfin_s <= '0;
            ben_s  <= '0;
            ben_d  <= 1'b0;
        end else begin
            rfin_s <= {rfin_s[0], rfin};
            ben_s  <= {ben_s[0], bit_en};
            ben_d  <= ben_s[1];
        end
    end

    // receive FSM: hunt for sync, capture payload, drain bytes while still hunting for a newer sync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= R_HUNT;
            sync_sr  <= '0;
            pay      <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            pkt_rec  <= 1'b0;
            pkt_drop <= 1'b0;
        end else begin
            pkt_rec  <= 1'b0;
            pkt_drop <= 1'b0;
            if (!mode) begin
                rx_state <= R_HUNT;
                rx_valid <= 1'b0;
                sync_sr  <= '0;
                bit_cnt  <= '0;
                idx      <= '0;
            end else begin
                case (rx_state)
                    R_HUNT: if (bit_ev) begin
                        sync_sr <= sync_hit ? '0 : sync_nx;
                        if (sync_hit) begin
                            rx_state <= R_PAYLOAD;
                            bit_cnt  <= '0;
                        end
                    end
                    R_PAYLOAD: if (bit_ev) begin
                        pay     <= pay_nx;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BCW'(PW - 1)) begin
                            rx_state <= R_DRAIN;
                            pkt_rec  <= 1'b1;
                            idx      <= '0;
                            rx_valid <= 1'b1;
                            rx_byte  <= byte_at(pay_nx, '0);
                        end
                    end
                    R_DRAIN: begin
                        if (bit_ev)
                            sync_sr <= sync_hit ? '0 : sync_nx;
                        if (sync_hit) begin
                            rx_state <= R_PAYLOAD;
                            bit_cnt  <= '0;
                            rx_valid <= 1'b0;
                            pkt_drop <= !(rx_hs && rx_last);
                        end else if (rx_hs) begin
                            if (rx_last) begin
                                rx_state <= R_HUNT;
                                rx_valid <= 1'b0;
                            end else begin
                                idx     <= idx + 1'b1;
                                rx_byte <= byte_at(pay, idx + 1'b1);
                            end
                        end
                    end
                    default: rx_state <= R_HUNT;
                endcase
            end
        end
    end

    // transmit FSM: accept a byte when idle, then step it out MSB first on each bit event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_sr    <= '0;
            tx_cnt   <= '0;
            tx_ready <= 1'b0;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b0;
        end else if (mode) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_ready <= 1'b0;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b0;
        end else if (tx_state == T_IDLE) begin
            tx_ready <= !tx_hs;
            if (tx_hs) begin
                tx_state <= T_SHIFT;
                tx_sr    <= tx_byte;
                tx_out   <= tx_byte[DW-1];
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
            end
        end else if (bit_ev) begin
            tx_sr  <= tx_sr << 1;
            tx_cnt <= tx_cnt + 1'b1;
            tx_out <= (tx_cnt == TCW'(DW - 1)) ? 1'b0 : tx_sr[DW-2];
            if (tx_cnt == TCW'(DW - 1)) begin
                tx_state <= T_IDLE;
                tx_busy  <= 1'b0;
                tx_ready <= 1'b1;
            end
        end
    end
endmodule

// File: doc/rf_pkt_ctrl.md
RF_PKT_CTRL -- requirements
Module: rf_pkt_ctrl

Interface
REQ-001 Parameter DW, 8, data byte width in bits (>=2).
REQ-002 Parameter PKT_BYTES, 8, payload bytes per packet (>=1).
REQ-003 Parameter SYNC_W, 16, sync word width in bits (>=2).
REQ-004 Parameter SYNC_WORD, 16'hA5C3, sync pattern, MSB received first.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 mode  in  1  1 = RX path active, 0 = TX path active.
REQ-008 rfin  in  1  asynchronous serial RF data.
REQ-009 bit_en  in  1  asynchronous bit strobe; its rising edge marks one bit time.
REQ-010 rx_byte  out  DW  current payload byte to host.
REQ-011 rx_valid  out  1  rx_byte valid.
REQ-012 rx_ready  in  1  host accepts rx_byte.
REQ-013 pkt_rec  out  1  one-cycle pulse when a full payload has been captured.
REQ-014 pkt_drop  out  1  one-cycle pulse when an undrained packet is discarded.
REQ-015 tx_byte  in  DW  byte to transmit.
REQ-016 tx_valid  in  1  tx_byte valid.
REQ-017 tx_ready  out  1  TX path accepts a byte.
REQ-018 tx_out  out  1  serial TX data, MSB first.
REQ-019 tx_busy  out  1  high while a byte is being serialised.

Function
REQ-020 rfin and bit_en SHALL each pass through a 2-flop synchroniser; a bit event SHALL be the cycle in which synced bit_en goes 0->1, 3 clk after the bit_en edge.
REQ-021 RX FSM states: R_HUNT, R_PAYLOAD, R_DRAIN; RX FSM SHALL advance only when mode=1.
REQ-022 R_HUNT: on each bit event, shift synced rfin into a SYNC_W register (LSB in); when the register equals SYNC_WORD, go to R_PAYLOAD, clear the bit counter and the sync register.
REQ-023 R_PAYLOAD: on each bit event, shift rfin into a PKT_BYTES*DW buffer, MSB first; on bit PKT_BYTES*DW, pulse pkt_rec the following cycle, set byte index to 0, go to R_DRAIN.
REQ-024 R_DRAIN: rx_valid=1, rx_byte=buffer byte[index] (byte 0 = first received); on rx_valid&&rx_ready, increment index; transfer of byte PKT_BYTES-1 returns to R_HUNT with rx_valid=0 the next cycle.
REQ-025 rx_byte SHALL hold stable while rx_valid=1 and rx_ready=0.
REQ-026 In R_DRAIN, sync hunting SHALL continue on bit events; a sync match SHALL pulse pkt_drop, deassert rx_valid next cycle, and enter R_PAYLOAD for the new packet.
REQ-027 TX FSM states: T_IDLE, T_SHIFT; TX FSM SHALL advance only when mode=0.
REQ-028 T_IDLE: tx_ready=1, tx_out=0; tx_valid&&tx_ready latches tx_byte, goes to T_SHIFT, tx_out=tx_byte[DW-1] the next cycle.
REQ-029 T_SHIFT: tx_ready=0, tx_busy=1; each bit event presents the next lower bit on tx_out; the DW-th bit event returns to T_IDLE with tx_out=0.
REQ-030 mode=0 SHALL force the RX FSM to R_HUNT with rx_valid=0, without pulsing pkt_rec or pkt_drop; mode=1 SHALL force the TX FSM to T_IDLE with tx_ready=0, tx_out=0, tx_busy=0.
REQ-031 Bit counter and byte index widths SHALL be $clog2 of their limits plus 1; no wrap beyond the limits.

Reset
REQ-032 On rst: both FSMs idle (R_HUNT, T_IDLE); rx_byte=0, rx_valid=0, pkt_rec=0, pkt_drop=0, tx_out=0, tx_busy=0; synchronisers, shift registers and counters cleared.
REQ-033 Out of reset, tx_ready SHALL equal ~mode.
REQ-034 rst mid-packet SHALL discard all partial state with no pkt_rec or pkt_drop pulse.

Verification (DW=8, PKT_BYTES=4, SYNC_WORD=16'hA5C3)
REQ-035 Reset, mode=1 -> all outputs 0, tx_ready=0; mode=0 -> tx_ready=1.
REQ-036 mode=1, bits A5C3 DEADBEEF, rx_ready=1 -> one pkt_rec pulse; rx_byte DE,AD,BE,EF on 4 handshakes; then rx_valid=0.
REQ-037 Same packet, rx_ready=0 for 10 cycles at byte 1 -> rx_byte holds AD, rx_valid stays 1.
REQ-038 In R_DRAIN with rx_ready=0, send A5C3 11223344 -> pkt_drop pulse; rx_valid drops; new packet drains 11,22,33,44.
REQ-039 mode=0, tx_byte=8'h96 handshake -> tx_out 1,0,0,1,0,1,1,0 across 8 bit events; tx_busy high, tx_ready low throughout; then tx_out=0.
REQ-040 rst after 20 payload bits -> R_HUNT; no pkt_rec; next full packet is received correctly.
